// File: rtl/stage_sequencer_if.sv
// Fetch, decode and bus-side signals of the stage sequencer.
// The sequencer takes the master side; memory, decode and bus unit take the slave side.
interface stage_sequencer_if #(
  parameter int INSTR_WIDTH  = 16,
  parameter int I_ADDR_WIDTH = 10,
  parameter int CNT_WIDTH    = 16
);
  logic [INSTR_WIDTH-1:0]  instruction;
  logic [I_ADDR_WIDTH-1:0] program_counter;
  logic [INSTR_WIDTH-1:0]  instr_buffer;
  logic [INSTR_WIDTH-1:0]  instr_ext;
  logic                    two_word;
  logic                    mem_access;
  logic                    mem_req;
  logic                    mem_ready;
  logic                    pc_load;
  logic [I_ADDR_WIDTH-1:0] pc_target;
  logic                    halt;
  logic [6:0]              pipeline_stage;
  logic                    timeout;
  logic [CNT_WIDTH-1:0]    retired;

  modport master (
    input  instruction, two_word, mem_access, mem_ready, pc_load, pc_target, halt,
    output program_counter, instr_buffer, instr_ext, mem_req, pipeline_stage,
           timeout, retired
  );

  modport slave (
    output instruction, two_word, mem_access, mem_ready, pc_load, pc_target, halt,
    input  program_counter, instr_buffer, instr_ext, mem_req, pipeline_stage,
           timeout, retired
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC and instruction buffers, steps
// IF/IF2/ID/EX/MEM/WB, handles MEM wait states with timeout, and counts retirements.
//
// state  | meaning
// S_IF   | fetch first word, PC+1
// S_IF2  | fetch second word of a two-word instruction, PC+1
// S_ID   | decode
// S_EX   | execute; choose MEM or WB
// S_MEM  | bus access, waits for mem_ready up to WAIT_LIMIT cycles
// S_WB   | retire, optional PC load, optional halt
// S_HALT | frozen until reset
module stage_sequencer #(
  parameter int INSTR_WIDTH  = 16,
  parameter int I_ADDR_WIDTH = 10,
  parameter int WAIT_LIMIT   = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                reset,
  stage_sequencer_if.master   bus
);

  localparam int WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IF, S_IF2, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  state_t                  state_q,    state_d;
  logic [I_ADDR_WIDTH-1:0] pc_q,       pc_d;
  logic [INSTR_WIDTH-1:0]  ibuf_q,     ibuf_d;
  logic [INSTR_WIDTH-1:0]  iext_q,     iext_d;
  logic                    timeout_q,  timeout_d;
  logic [CNT_WIDTH-1:0]    retired_q,  retired_d;
  logic [WCW-1:0]          wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IF;
      pc_q       <= '0;
      ibuf_q     <= '0;
      iext_q     <= '0;
      timeout_q  <= 1'b0;
      retired_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ibuf_q     <= ibuf_d;
      iext_q     <= iext_d;
      timeout_q  <= timeout_d;
      retired_q  <= retired_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ibuf_d     = ibuf_q;
    iext_d     = iext_q;
    timeout_d  = timeout_q;
    retired_d  = retired_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_IF: begin
        ibuf_d  = bus.instruction;
        pc_d    = pc_q + I_ADDR_WIDTH'(1);
        state_d = bus.two_word ? S_IF2 : S_ID;
      end
      S_IF2: begin
        iext_d  = bus.instruction;
        pc_d    = pc_q + I_ADDR_WIDTH'(1);
        state_d = S_ID;
      end
      S_ID: state_d = S_EX;
      S_EX: state_d = bus.mem_access ? S_MEM : S_WB;
      S_MEM: begin
        // a ready on the last allowed cycle still wins over the timeout
        if (bus.mem_ready) begin
          wait_cnt_d = '0;
          state_d    = S_WB;
        end else if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          timeout_d  = 1'b1;
          state_d    = S_WB;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      S_WB: begin
        retired_d = retired_q + CNT_WIDTH'(1);
        if (bus.pc_load) pc_d = bus.pc_target;
        state_d = bus.halt ? S_HALT : S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    bus.pipeline_stage = 7'b0000000;
    unique case (state_q)
      S_IF:    bus.pipeline_stage = 7'b0000001;
      S_IF2:   bus.pipeline_stage = 7'b0000010;
      S_ID:    bus.pipeline_stage = 7'b0000100;
      S_EX:    bus.pipeline_stage = 7'b0001000;
      S_MEM:   bus.pipeline_stage = 7'b0010000;
      S_WB:    bus.pipeline_stage = 7'b0100000;
      S_HALT:  bus.pipeline_stage = 7'b1000000;
      default: bus.pipeline_stage = 7'b0000000;
    endcase
  end

  assign bus.mem_req         = (state_q == S_MEM);
  assign bus.program_counter = pc_q;
  assign bus.instr_buffer    = ibuf_q;
  assign bus.instr_ext       = iext_q;
  assign bus.timeout         = timeout_q;
  assign bus.retired         = retired_q;

endmodule
